// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states, fetch payload and
// the opcode constants the control unit decodes.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned ADDR_W   = 16;

  typedef enum logic [1:0] {
    READY = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetchStateT;

  // One fetched instruction together with the address of its successor.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pcPlus2;
  } fetchEntryT;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_LW  = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_SW  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'b1111;

  function automatic logic [OPCODE_W-1:0] opcodeOf(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for an instruction that returned while decode
// was stalled. Clear wins over load; a load in the same cycle as a pop refills.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  fetchEntryT loadEntry,
  input  logic       pop,
  input  logic       clear,
  output logic       full,
  output fetchEntryT entry
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      entry <= loadEntry;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and
// fills the IF/ID register. Define IFETCH_PREFETCH_EN to keep fetching one
// instruction ahead into the hold buffer while decode is stalled.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned       PC_STEP  = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [ADDR_W-1:0]   BranchTarget,
  output logic                ImemReq,
  output logic [ADDR_W-1:0]   ImemAddr,
  input  logic                ImemAck,
  input  logic [INSTR_W-1:0]  ImemRdata,
  output logic                IfIdValid,
  output logic [INSTR_W-1:0]  IfIdInstr,
  output logic [ADDR_W-1:0]   IfIdPcPlus2,
  output logic [OPCODE_W-1:0] Opcode
);

`ifdef IFETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  fetchStateT         state, stateNext;
  logic [ADDR_W-1:0]  pc, pcNext, pcPlusStep, branchPc;
  logic               ifIdValid, ifIdValidNext;
  logic [INSTR_W-1:0] ifIdInstr, ifIdInstrNext;
  logic [ADDR_W-1:0]  ifIdPcPlus2, ifIdPcPlus2Next;
  logic               holdFull, holdLoad, holdPop, holdClear;
  fetchEntryT         holdEntry, ackEntry;
  logic               permit, imemReq;

  assign pcPlusStep = pc + ADDR_W'(PC_STEP);
  assign branchPc   = BranchTarget & {{(ADDR_W-1){1'b1}}, 1'b0};
  assign ackEntry   = '{instr: ImemRdata, pcPlus2: pcPlusStep};

  assign permit  = !holdFull && !BranchTaken && (!Stall || PREFETCH);
  assign imemReq = (state == READY) && permit && !Reset;

  fetch_hold_buf u_hold (
    .clk      (Clock),
    .rst      (Reset),
    .load     (holdLoad),
    .loadEntry(ackEntry),
    .pop      (holdPop),
    .clear    (holdClear),
    .full     (holdFull),
    .entry    (holdEntry)
  );

  // Next state, PC and IF/ID; a branch overrides stall and flushes everything.
  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    ifIdValidNext   = ifIdValid;
    ifIdInstrNext   = ifIdInstr;
    ifIdPcPlus2Next = ifIdPcPlus2;
    holdLoad        = 1'b0;
    holdPop         = 1'b0;
    holdClear       = 1'b0;

    if (BranchTaken) begin
      pcNext        = branchPc;
      ifIdValidNext = 1'b0;
      holdClear     = 1'b1;
      case (state)
        READY:   stateNext = READY;
        WAIT:    stateNext = ImemAck ? READY : DROP;
        DROP:    stateNext = ImemAck ? READY : DROP;
        default: stateNext = READY;
      endcase
    end else begin
      if (holdFull && !Stall) begin
        ifIdValidNext   = 1'b1;
        ifIdInstrNext   = holdEntry.instr;
        ifIdPcPlus2Next = holdEntry.pcPlus2;
        holdPop         = 1'b1;
      end
      case (state)
        READY: begin
          if (imemReq) stateNext = WAIT;
        end
        WAIT: begin
          if (ImemAck) begin
            stateNext = READY;
            pcNext    = pcPlusStep;
            // A draining hold entry takes IF/ID first; the new word refills the hold.
            if (!holdFull && (!Stall || !ifIdValid)) begin
              ifIdValidNext   = 1'b1;
              ifIdInstrNext   = ImemRdata;
              ifIdPcPlus2Next = pcPlusStep;
            end else begin
              holdLoad = 1'b1;
            end
          end
        end
        DROP: begin
          if (ImemAck) stateNext = READY;
        end
        default: stateNext = READY;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= READY;
      pc          <= RESET_PC;
      ifIdValid   <= 1'b0;
      ifIdInstr   <= '0;
      ifIdPcPlus2 <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      ifIdValid   <= ifIdValidNext;
      ifIdInstr   <= ifIdInstrNext;
      ifIdPcPlus2 <= ifIdPcPlus2Next;
    end
  end

  assign ImemReq     = imemReq;
  assign ImemAddr    = pc;
  assign IfIdValid   = ifIdValid;
  assign IfIdInstr   = ifIdInstr;
  assign IfIdPcPlus2 = ifIdPcPlus2;
  assign Opcode      = opcodeOf(ifIdInstr);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle memory responder and a
// scoreboard of instructions expected to reach IF/ID.
module tb_instr_fetch;

  logic        Clock, Reset, Stall, BranchTaken, ImemAck, ImemReq, IfIdValid;
  logic [15:0] BranchTarget, ImemAddr, ImemRdata, IfIdInstr, IfIdPcPlus2;
  logic [3:0]  Opcode;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcPlus2;
  } expT;

  expT         expQ[$];
  expT         discard;
  int          nAssert = 0;
  int          nFail = 0;
  int          reqCount;
  logic        reqPrev;
  logic [15:0] addrPrev;

  instr_fetch #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemRdata   (ImemRdata),
    .IfIdValid   (IfIdValid),
    .IfIdInstr   (IfIdInstr),
    .IfIdPcPlus2 (IfIdPcPlus2),
    .Opcode      (Opcode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'hC567;
      16'h0004: return 16'h7ABC;
      default:  return a ^ 16'hA5C3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    nAssert++;
    assert (obs === want) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic want);
    nAssert++;
    assert (obs === want) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then note any request issued.
  task automatic cyc(input logic s, input logic b, input logic [15:0] t,
                     input logic a, input logic [15:0] d);
    @(negedge Clock);
    Stall = s; BranchTaken = b; BranchTarget = t; ImemAck = a; ImemRdata = d;
    #1;
    reqPrev  = ImemReq;
    addrPrev = ImemAddr;
  endtask

  // One cycle with the 1-cycle memory answering last cycle's request.
  task automatic mc(input logic s, input logic b, input logic [15:0] t);
    logic        a;
    logic [15:0] d;
    a = reqPrev;
    d = memWord(addrPrev);
    if (a && !b) expQ.push_back({d, addrPrev + 16'd2});
    cyc(s, b, t, a, d);
  endtask

  task automatic popCheck(input string tag);
    expT e;
    chkBit({tag, "_avail"}, expQ.size() != 0, 1'b1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      chkBit({tag, "_valid"}, IfIdValid, 1'b1);
      chk({tag, "_instr"}, IfIdInstr, e.instr);
      chk({tag, "_pc2"}, IfIdPcPlus2, e.pcPlus2);
      chk({tag, "_op"}, {12'h000, Opcode}, {12'h000, e.instr[15:12]});
    end
  endtask

  task automatic chkReq(input string tag, input logic [15:0] addr);
    chkBit({tag, "_req"}, ImemReq, 1'b1);
    chk({tag, "_addr"}, ImemAddr, addr);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    ImemAck = 1'b0; ImemRdata = '0; reqPrev = 1'b0; addrPrev = '0;

    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    chkBit("rst_req", ImemReq, 1'b0);
    chk("rst_addr", ImemAddr, 16'h0000);
    chkBit("rst_valid", IfIdValid, 1'b0);
    chk("rst_instr", IfIdInstr, 16'h0000);
    chk("rst_pc2", IfIdPcPlus2, 16'h0000);
    chk("rst_op", {12'h000, Opcode}, 16'h0000);

    // First request in the first cycle after reset release.
    @(negedge Clock); Reset = 1'b0; #1;
    reqPrev = ImemReq; addrPrev = ImemAddr;
    chkReq("first", 16'h0000);
    mc(0, 0, 16'h0);
    chkBit("ack1_req", ImemReq, 1'b0);
    mc(0, 0, 16'h0);
    popCheck("i1");
    chkReq("second", 16'h0002);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    popCheck("i2");
    chkReq("third", 16'h0004);

    // Stall five cycles with a request already in flight: response parks in hold.
    mc(1, 0, 16'h0);
    chkBit("stall0_req", ImemReq, 1'b0);
    repeat (4) begin
      mc(1, 0, 16'h0);
      chk("stall_instr", IfIdInstr, 16'hC567);
      chkBit("stall_req", ImemReq, 1'b0);
    end
    mc(0, 0, 16'h0);
    chkBit("unstall_req", ImemReq, 1'b0);
    mc(0, 0, 16'h0);
    popCheck("i3");
    chkReq("after_hold", 16'h0006);

    // Stall beginning in READY: prefetch issues exactly one request.
    mc(0, 0, 16'h0);
    mc(1, 0, 16'h0);
    popCheck("i4");
    reqCount = int'(ImemReq);
    repeat (4) begin
      mc(1, 0, 16'h0);
      reqCount += int'(ImemReq);
      chk("pf_hold_instr", IfIdInstr, 16'h0006 ^ 16'hA5C3);
    end
`ifdef IFETCH_PREFETCH_EN
    chk("stall_reqs", 16'(reqCount), 16'd1);
    mc(0, 0, 16'h0);
    chkBit("pf_drain_req", ImemReq, 1'b0);
    mc(0, 0, 16'h0);
`else
    chk("stall_reqs", 16'(reqCount), 16'd0);
    mc(0, 0, 16'h0);
    chkReq("resume", 16'h0008);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
`endif
    popCheck("i5");
    chkReq("post_stall", 16'h000A);

    // Branch in the same cycle as the ack: data dropped, odd target aligned.
    mc(0, 1, 16'h0041);
    chkBit("br_ack_req", ImemReq, 1'b0);
    mc(0, 0, 16'h0);
    chkBit("br_valid", IfIdValid, 1'b0);
    chkReq("br_target", 16'h0040);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    popCheck("i6");
    chkReq("br_next", 16'h0042);

    // Branch while waiting on a slow memory: the late ack must be discarded.
    cyc(0, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'h0100, 0, 16'h0);
    chkBit("wait_br_req", ImemReq, 1'b0);
    cyc(0, 0, 16'h0, 1, 16'hDEAD);
    chkBit("drop_req", ImemReq, 1'b0);
    cyc(0, 0, 16'h0, 0, 16'h0);
    chkBit("drop_valid", IfIdValid, 1'b0);
    chkReq("drop_target", 16'h0100);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    popCheck("i7");
    chkReq("drop_next", 16'h0102);

    // Branch together with Stall while the hold buffer is full.
    mc(1, 0, 16'h0);
    mc(1, 1, 16'h0201);
    discard = expQ.pop_back();
    chkBit("flush_br_req", ImemReq, 1'b0);
    mc(0, 0, 16'h0);
    chkBit("flush_valid", IfIdValid, 1'b0);
    chkReq("flush_target", 16'h0200);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    popCheck("i8");
    chkReq("flush_next", 16'h0202);

    // PC wrap at the top of the address space.
    mc(0, 1, 16'hFFFE);
    mc(0, 0, 16'h0);
    chkReq("wrap_fetch", 16'hFFFE);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    popCheck("wrap");
    chkReq("wrap_next", 16'h0000);
    mc(0, 0, 16'h0);
    mc(0, 0, 16'h0);
    popCheck("i10");
    chkReq("pre_arst", 16'h0002);

    // Asynchronous reset while WAIT, then an ack arriving in READY is ignored.
    @(negedge Clock); ImemAck = 1'b0; #2; Reset = 1'b1; #1;
    chkBit("arst_req", ImemReq, 1'b0);
    chk("arst_addr", ImemAddr, 16'h0000);
    chkBit("arst_valid", IfIdValid, 1'b0);
    chk("arst_instr", IfIdInstr, 16'h0000);
    chk("arst_pc2", IfIdPcPlus2, 16'h0000);
    chk("arst_op", {12'h000, Opcode}, 16'h0000);
    @(negedge Clock); Reset = 1'b0; ImemAck = 1'b1; ImemRdata = 16'hBEEF; #1;
    reqPrev = ImemReq; addrPrev = ImemAddr;
    chkReq("post_rst", 16'h0000);
    mc(0, 0, 16'h0);
    chkBit("late_ack_valid", IfIdValid, 1'b0);
    mc(0, 0, 16'h0);
    popCheck("i11");
    chk("sb_empty", 16'(expQ.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
